// File: rtl/mips_decode_pkg.sv
// Shared encodings for the MIPS decode stage: opcodes, functs, control-word
// bit positions and the per-instruction decode flags bundle.
package mips_decode_pkg;

   localparam int NB_CTRL_DEF = 12;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_HALT  = 6'h3F;

   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   localparam int CTRL_REG_WRITE  = 0;
   localparam int CTRL_MEM_READ   = 1;
   localparam int CTRL_MEM_WRITE  = 2;
   localparam int CTRL_MEM_TO_REG = 3;
   localparam int CTRL_ALU_SRC    = 4;
   localparam int CTRL_REG_DST    = 5;
   localparam int CTRL_LINK       = 6;
   localparam int CTRL_HALT       = 7;
   localparam int CTRL_ALU_OP     = 8;
   localparam int NB_ALU_OP       = 4;

   // ALU_FUNCT tells EX to take the operation from the R-type funct field
   localparam logic [3:0] ALU_FUNCT = 4'h0;
   localparam logic [3:0] ALU_ADD   = 4'h1;
   localparam logic [3:0] ALU_SUB   = 4'h2;
   localparam logic [3:0] ALU_AND   = 4'h3;
   localparam logic [3:0] ALU_OR    = 4'h4;
   localparam logic [3:0] ALU_SLT   = 4'h5;
   localparam logic [3:0] ALU_LUI   = 4'h6;

   typedef struct packed {
      logic branch;
      logic bne;
      logic jump;
      logic jr;
      logic uses_rs;
      logic uses_rt;
      logic zext_imm;
   } dec_flags_t;

endpackage

// File: rtl/decode_ctrl.sv
// Combinational opcode/funct decoder producing the packed control word and
// the branch/jump/operand-usage flags consumed by the decode stage.
module decode_ctrl
   import mips_decode_pkg::*;
#(
   parameter int NB_CTRL = NB_CTRL_DEF
) (
   input  logic [5:0]         opcode_i,
   input  logic [5:0]         funct_i,
   output logic [NB_CTRL-1:0] ctrl_o,
   output dec_flags_t         flags_o
);

   always_comb begin
      ctrl_o  = '0;
      flags_o = '0;
      case (opcode_i)
         OP_RTYPE: begin
            flags_o.uses_rs = 1'b1;
            if (funct_i == FN_JR) begin
               flags_o.jr = 1'b1;
            end else begin
               flags_o.uses_rt                   = 1'b1;
               ctrl_o[CTRL_REG_WRITE]            = 1'b1;
               ctrl_o[CTRL_REG_DST]              = 1'b1;
               ctrl_o[CTRL_ALU_OP +: NB_ALU_OP]  = ALU_FUNCT;
            end
         end
         OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
            flags_o.uses_rs        = 1'b1;
            flags_o.zext_imm       = (opcode_i == OP_ANDI) || (opcode_i == OP_ORI);
            ctrl_o[CTRL_REG_WRITE] = 1'b1;
            ctrl_o[CTRL_ALU_SRC]   = 1'b1;
            case (opcode_i)
               OP_SLTI: ctrl_o[CTRL_ALU_OP +: NB_ALU_OP] = ALU_SLT;
               OP_ANDI: ctrl_o[CTRL_ALU_OP +: NB_ALU_OP] = ALU_AND;
               OP_ORI:  ctrl_o[CTRL_ALU_OP +: NB_ALU_OP] = ALU_OR;
               default: ctrl_o[CTRL_ALU_OP +: NB_ALU_OP] = ALU_ADD;
            endcase
         end
         OP_LUI: begin
            ctrl_o[CTRL_REG_WRITE]           = 1'b1;
            ctrl_o[CTRL_ALU_SRC]             = 1'b1;
            ctrl_o[CTRL_ALU_OP +: NB_ALU_OP] = ALU_LUI;
         end
         OP_LW: begin
            flags_o.uses_rs                  = 1'b1;
            ctrl_o[CTRL_REG_WRITE]           = 1'b1;
            ctrl_o[CTRL_MEM_READ]            = 1'b1;
            ctrl_o[CTRL_MEM_TO_REG]          = 1'b1;
            ctrl_o[CTRL_ALU_SRC]             = 1'b1;
            ctrl_o[CTRL_ALU_OP +: NB_ALU_OP] = ALU_ADD;
         end
         OP_SW: begin
            flags_o.uses_rs                  = 1'b1;
            flags_o.uses_rt                  = 1'b1;
            ctrl_o[CTRL_MEM_WRITE]           = 1'b1;
            ctrl_o[CTRL_ALU_SRC]             = 1'b1;
            ctrl_o[CTRL_ALU_OP +: NB_ALU_OP] = ALU_ADD;
         end
         OP_BEQ, OP_BNE: begin
            flags_o.branch                   = 1'b1;
            flags_o.bne                      = (opcode_i == OP_BNE);
            flags_o.uses_rs                  = 1'b1;
            flags_o.uses_rt                  = 1'b1;
            ctrl_o[CTRL_ALU_OP +: NB_ALU_OP] = ALU_SUB;
         end
         OP_J: begin
            flags_o.jump = 1'b1;
         end
         OP_JAL: begin
            flags_o.jump           = 1'b1;
            ctrl_o[CTRL_REG_WRITE] = 1'b1;
            ctrl_o[CTRL_LINK]      = 1'b1;
         end
         OP_HALT: begin
            ctrl_o[CTRL_HALT] = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/decode_stage_pipelined.sv
// MIPS decode stage: register file, hazard detection, in-decode branch/jump
// resolution with EX/MEM and MEM/WB forwarding, sticky halt and ID/EX register.
module decode_stage_pipelined
   import mips_decode_pkg::*;
#(
   parameter int NB_DATA = 32,
   parameter int NB_REG  = 5,
   parameter int NB_CTRL = NB_CTRL_DEF
) (
   input  logic               clock_i,
   input  logic               reset_i,
   input  logic               if_valid_i,
   input  logic [NB_DATA-1:0] instruction_i,
   input  logic [NB_DATA-1:0] pc_i,
   input  logic               wb_write_i,
   input  logic [NB_REG-1:0]  wb_addr_i,
   input  logic [NB_DATA-1:0] wb_data_i,
   input  logic               exmem_reg_write_i,
   input  logic               exmem_mem_read_i,
   input  logic [NB_REG-1:0]  exmem_addr_i,
   input  logic [NB_DATA-1:0] exmem_data_i,
   input  logic [NB_REG-1:0]  debug_addr_i,
   output logic [NB_DATA-1:0] debug_data_o,
   output logic               stall_o,
   output logic               flush_o,
   output logic               pc_load_o,
   output logic [NB_DATA-1:0] pc_next_o,
   output logic               ex_valid_o,
   output logic [NB_DATA-1:0] ex_pc_o,
   output logic [NB_DATA-1:0] ex_data_a_o,
   output logic [NB_DATA-1:0] ex_data_b_o,
   output logic [NB_DATA-1:0] ex_imm_o,
   output logic [NB_REG-1:0]  ex_rs_o,
   output logic [NB_REG-1:0]  ex_rt_o,
   output logic [NB_REG-1:0]  ex_rd_o,
   output logic [NB_CTRL-1:0] ex_ctrl_o,
   output logic               halted_o
);

   localparam int                N_REGS   = 2**NB_REG;
   localparam logic [NB_REG-1:0] REG_LINK = NB_REG'(31);

   logic [NB_DATA-1:0] r_regs [N_REGS];
   logic               r_halted;
   logic               r_ex_valid;
   logic [NB_DATA-1:0] r_ex_pc, r_ex_data_a, r_ex_data_b, r_ex_imm;
   logic [NB_REG-1:0]  r_ex_rs, r_ex_rt, r_ex_rd;
   logic [NB_CTRL-1:0] r_ex_ctrl;

   logic [5:0]         w_opcode, w_funct;
   logic [NB_REG-1:0]  w_rs, w_rt, w_rd, w_dest;
   logic [15:0]        w_imm16;
   logic [25:0]        w_index;
   logic [NB_CTRL-1:0] w_ctrl;
   dec_flags_t         w_flags;
   logic [NB_DATA-1:0] w_rd_rs, w_rd_rt, w_br_a, w_br_b;
   logic [NB_DATA-1:0] w_imm_sext, w_imm_ext, w_pc_plus4;
   logic [NB_DATA-1:0] w_br_target, w_j_target;
   logic               w_exmem_fwd_ok, w_load_use, w_idex_dep, w_exmem_dep;
   logic               w_hazard, w_taken, w_issue, w_redirect;
   logic               w_unused_instr;

   assign w_opcode       = instruction_i[31:26];
   assign w_funct        = instruction_i[5:0];
   assign w_rs           = NB_REG'(instruction_i[25:21]);
   assign w_rt           = NB_REG'(instruction_i[20:16]);
   assign w_rd           = NB_REG'(instruction_i[15:11]);
   assign w_imm16        = instruction_i[15:0];
   assign w_index        = instruction_i[25:0];
   assign w_unused_instr = ^instruction_i;

   decode_ctrl #(.NB_CTRL(NB_CTRL)) u_decode_ctrl (
      .opcode_i (w_opcode),
      .funct_i  (w_funct),
      .ctrl_o   (w_ctrl),
      .flags_o  (w_flags)
   );

   // Register 0 is never written, so its storage stays zero after reset
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         for (int i = 0; i < N_REGS; i++) r_regs[i] <= '0;
      end else if (wb_write_i && (wb_addr_i != '0)) begin
         r_regs[wb_addr_i] <= wb_data_i;
      end
   end

   assign w_rd_rs      = (wb_write_i && (wb_addr_i == w_rs) && (w_rs != '0))
                         ? wb_data_i : r_regs[w_rs];
   assign w_rd_rt      = (wb_write_i && (wb_addr_i == w_rt) && (w_rt != '0))
                         ? wb_data_i : r_regs[w_rt];
   assign debug_data_o = (wb_write_i && (wb_addr_i == debug_addr_i) && (debug_addr_i != '0))
                         ? wb_data_i : r_regs[debug_addr_i];

   // A load in EX/MEM has no data yet, so only ALU results are forwarded
   assign w_exmem_fwd_ok = exmem_reg_write_i && !exmem_mem_read_i;
   assign w_br_a = (w_exmem_fwd_ok && (exmem_addr_i == w_rs) && (w_rs != '0))
                   ? exmem_data_i : w_rd_rs;
   assign w_br_b = (w_exmem_fwd_ok && (exmem_addr_i == w_rt) && (w_rt != '0))
                   ? exmem_data_i : w_rd_rt;

   assign w_load_use  = r_ex_ctrl[CTRL_MEM_READ] && (r_ex_rt != '0) &&
                        ((w_flags.uses_rs && (r_ex_rt == w_rs)) ||
                         (w_flags.uses_rt && (r_ex_rt == w_rt)));
   assign w_idex_dep  = r_ex_ctrl[CTRL_REG_WRITE] && (r_ex_rd != '0) &&
                        ((w_flags.uses_rs && (r_ex_rd == w_rs)) ||
                         (w_flags.uses_rt && (r_ex_rd == w_rt)));
   assign w_exmem_dep = exmem_mem_read_i && (exmem_addr_i != '0) &&
                        ((w_flags.uses_rs && (exmem_addr_i == w_rs)) ||
                         (w_flags.uses_rt && (exmem_addr_i == w_rt)));
   assign w_hazard    = w_load_use ||
                        ((w_flags.branch || w_flags.jr) && (w_idex_dep || w_exmem_dep));

   assign stall_o    = reset_i && (r_halted || (if_valid_i && w_hazard));
   assign w_issue    = reset_i && if_valid_i && !stall_o;
   assign w_taken    = (w_flags.branch && ((w_br_a == w_br_b) ^ w_flags.bne)) ||
                       w_flags.jump || w_flags.jr;
   assign w_redirect = w_issue && w_taken;
   assign pc_load_o  = w_redirect;
   assign flush_o    = w_redirect;

   assign w_imm_sext  = {{(NB_DATA-16){w_imm16[15]}}, w_imm16};
   assign w_imm_ext   = w_flags.zext_imm ? {{(NB_DATA-16){1'b0}}, w_imm16} : w_imm_sext;
   assign w_pc_plus4  = pc_i + NB_DATA'(4);
   assign w_br_target = pc_i + (w_imm_sext << 2);
   assign w_j_target  = {pc_i[NB_DATA-1:28], w_index, 2'b00};

   always_comb begin
      pc_next_o = w_br_target;
      if (w_flags.jump)    pc_next_o = w_j_target;
      else if (w_flags.jr) pc_next_o = w_br_a;
   end

   always_comb begin
      w_dest = w_rt;
      if (w_ctrl[CTRL_LINK])         w_dest = REG_LINK;
      else if (w_ctrl[CTRL_REG_DST]) w_dest = w_rd;
   end

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         r_ex_valid  <= 1'b0;
         r_ex_pc     <= '0;
         r_ex_data_a <= '0;
         r_ex_data_b <= '0;
         r_ex_imm    <= '0;
         r_ex_rs     <= '0;
         r_ex_rt     <= '0;
         r_ex_rd     <= '0;
         r_ex_ctrl   <= '0;
      end else if (w_issue) begin
         r_ex_valid  <= 1'b1;
         r_ex_pc     <= pc_i;
         r_ex_data_a <= w_ctrl[CTRL_LINK] ? w_pc_plus4 : w_rd_rs;
         r_ex_data_b <= w_rd_rt;
         r_ex_imm    <= w_imm_ext;
         r_ex_rs     <= w_rs;
         r_ex_rt     <= w_rt;
         r_ex_rd     <= w_dest;
         r_ex_ctrl   <= w_ctrl;
      end else begin
         r_ex_valid  <= 1'b0;
         r_ex_pc     <= '0;
         r_ex_data_a <= '0;
         r_ex_data_b <= '0;
         r_ex_imm    <= '0;
         r_ex_rs     <= '0;
         r_ex_rt     <= '0;
         r_ex_rd     <= '0;
         r_ex_ctrl   <= '0;
      end
   end

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i)                              r_halted <= 1'b0;
      else if (w_issue && w_ctrl[CTRL_HALT])     r_halted <= 1'b1;
   end

   assign ex_valid_o  = r_ex_valid;
   assign ex_pc_o     = r_ex_pc;
   assign ex_data_a_o = r_ex_data_a;
   assign ex_data_b_o = r_ex_data_b;
   assign ex_imm_o    = r_ex_imm;
   assign ex_rs_o     = r_ex_rs;
   assign ex_rt_o     = r_ex_rt;
   assign ex_rd_o     = r_ex_rd;
   assign ex_ctrl_o   = r_ex_ctrl;
   assign halted_o    = r_halted;

endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Bench for decode_stage_pipelined: a per-cycle vector table with an ID/EX
// scoreboard queue, plus hand sequences for debug reads, halt and reset.
module tb_decode_stage_pipelined;
   import mips_decode_pkg::*;

   logic        clock_i = 1'b0;
   logic        reset_i;
   logic        if_valid_i;
   logic [31:0] instruction_i, pc_i;
   logic        wb_write_i;
   logic [4:0]  wb_addr_i;
   logic [31:0] wb_data_i;
   logic        exmem_reg_write_i, exmem_mem_read_i;
   logic [4:0]  exmem_addr_i;
   logic [31:0] exmem_data_i;
   logic [4:0]  debug_addr_i;
   logic [31:0] debug_data_o;
   logic        stall_o, flush_o, pc_load_o;
   logic [31:0] pc_next_o;
   logic        ex_valid_o;
   logic [31:0] ex_pc_o, ex_data_a_o, ex_data_b_o, ex_imm_o;
   logic [4:0]  ex_rs_o, ex_rt_o, ex_rd_o;
   logic [11:0] ex_ctrl_o;
   logic        halted_o;

   decode_stage_pipelined #(.NB_DATA(32), .NB_REG(5), .NB_CTRL(12)) dut (
      .clock_i(clock_i), .reset_i(reset_i), .if_valid_i(if_valid_i),
      .instruction_i(instruction_i), .pc_i(pc_i),
      .wb_write_i(wb_write_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
      .exmem_reg_write_i(exmem_reg_write_i), .exmem_mem_read_i(exmem_mem_read_i),
      .exmem_addr_i(exmem_addr_i), .exmem_data_i(exmem_data_i),
      .debug_addr_i(debug_addr_i), .debug_data_o(debug_data_o),
      .stall_o(stall_o), .flush_o(flush_o), .pc_load_o(pc_load_o), .pc_next_o(pc_next_o),
      .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o), .ex_data_a_o(ex_data_a_o),
      .ex_data_b_o(ex_data_b_o), .ex_imm_o(ex_imm_o), .ex_rs_o(ex_rs_o),
      .ex_rt_o(ex_rt_o), .ex_rd_o(ex_rd_o), .ex_ctrl_o(ex_ctrl_o), .halted_o(halted_o)
   );

   always #5 clock_i = ~clock_i;

   typedef struct {
      logic        v;
      logic [31:0] ins, pc;
      logic        wbw;
      logic [4:0]  wba;
      logic [31:0] wbd;
      logic        exw, exr;
      logic [4:0]  exa;
      logic [31:0] exd;
      logic        e_stall, e_load;
      logic [31:0] e_next;
      logic        e_valid;
      logic [4:0]  e_rs, e_rd;
      logic [31:0] e_a, e_b;
   } vec_t;

   typedef struct {
      int          idx;
      logic        valid;
      logic [4:0]  rs, rd;
      logic [31:0] a, b;
   } exp_t;

   int   checks   = 0;
   int   failures = 0;
   exp_t sb[$];
   vec_t tbl[20];

   function automatic logic [31:0] enc_r(int rs, int rt, int rd, logic [5:0] fn);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
   endfunction

   function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, logic [15:0] imm);
      return {op, 5'(rs), 5'(rt), imm};
   endfunction

   function automatic logic [31:0] enc_j(logic [5:0] op, logic [25:0] idx);
      return {op, idx};
   endfunction

   function automatic vec_t mk(logic v, logic [31:0] ins, logic [31:0] pc,
                               logic wbw, logic [4:0] wba, logic [31:0] wbd,
                               logic exw, logic exr, logic [4:0] exa, logic [31:0] exd,
                               logic es, logic el, logic [31:0] en,
                               logic ev, logic [4:0] ers, logic [4:0] erd,
                               logic [31:0] ea, logic [31:0] eb);
      vec_t t;
      t.v = v; t.ins = ins; t.pc = pc;
      t.wbw = wbw; t.wba = wba; t.wbd = wbd;
      t.exw = exw; t.exr = exr; t.exa = exa; t.exd = exd;
      t.e_stall = es; t.e_load = el; t.e_next = en;
      t.e_valid = ev; t.e_rs = ers; t.e_rd = erd; t.e_a = ea; t.e_b = eb;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic apply(input int idx, input vec_t t);
      exp_t e;
      @(negedge clock_i);
      if_valid_i = t.v; instruction_i = t.ins; pc_i = t.pc;
      wb_write_i = t.wbw; wb_addr_i = t.wba; wb_data_i = t.wbd;
      exmem_reg_write_i = t.exw; exmem_mem_read_i = t.exr;
      exmem_addr_i = t.exa; exmem_data_i = t.exd;
      #1;
      chk($sformatf("row%0d_stall", idx), 32'(stall_o), 32'(t.e_stall));
      chk($sformatf("row%0d_pc_load", idx), 32'(pc_load_o), 32'(t.e_load));
      chk($sformatf("row%0d_flush", idx), 32'(flush_o), 32'(t.e_load));
      if (t.e_load) chk($sformatf("row%0d_pc_next", idx), pc_next_o, t.e_next);
      e.idx = idx; e.valid = t.e_valid; e.rs = t.e_rs; e.rd = t.e_rd; e.a = t.e_a; e.b = t.e_b;
      sb.push_back(e);
      @(posedge clock_i);
      #1;
      if (sb.size() == 0) begin
         checks++; failures++;
         $display("FAIL row%0d_scoreboard: got empty want entry", idx);
      end else begin
         e = sb.pop_front();
         chk($sformatf("row%0d_ex_valid", e.idx), 32'(ex_valid_o), 32'(e.valid));
         chk($sformatf("row%0d_ex_rs", e.idx), 32'(ex_rs_o), 32'(e.rs));
         chk($sformatf("row%0d_ex_rd", e.idx), 32'(ex_rd_o), 32'(e.rd));
         chk($sformatf("row%0d_ex_a", e.idx), ex_data_a_o, e.a);
         chk($sformatf("row%0d_ex_b", e.idx), ex_data_b_o, e.b);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = mk(1, enc_r(5,0,7,FN_ADD), 32'h0,   1, 5'd5, 32'h1234, 0,0,5'd0,32'h0, 0,0,32'h0,   1, 5'd5, 5'd7, 32'h1234, 32'h0);
      tbl[1]  = mk(1, enc_r(0,5,8,FN_ADD), 32'h4,   1, 5'd0, 32'hDEAD, 0,0,5'd0,32'h0, 0,0,32'h0,   1, 5'd0, 5'd8, 32'h0, 32'h1234);
      tbl[2]  = mk(1, enc_r(0,0,9,FN_ADD), 32'h8,   0, 5'd0, 32'h0,    0,0,5'd0,32'h0, 0,0,32'h0,   1, 5'd0, 5'd9, 32'h0, 32'h0);
      tbl[3]  = mk(0, 32'h0, 32'h0,                 1, 5'd2, 32'h50,   0,0,5'd0,32'h0, 0,0,32'h0,   0, 5'd0, 5'd0, 32'h0, 32'h0);
      tbl[4]  = mk(0, 32'h0, 32'h0,                 1, 5'd4, 32'h7,    0,0,5'd0,32'h0, 0,0,32'h0,   0, 5'd0, 5'd0, 32'h0, 32'h0);
      tbl[5]  = mk(1, enc_i(OP_LW,1,2,16'h0), 32'h20, 0,5'd0,32'h0,   0,0,5'd0,32'h0, 0,0,32'h0,   1, 5'd1, 5'd2, 32'h0, 32'h50);
      tbl[6]  = mk(1, enc_r(2,4,3,FN_ADD), 32'h24,  0, 5'd0, 32'h0,    0,0,5'd0,32'h0, 1,0,32'h0,   0, 5'd0, 5'd0, 32'h0, 32'h0);
      tbl[7]  = mk(1, enc_r(2,4,3,FN_ADD), 32'h24,  0, 5'd0, 32'h0,    0,0,5'd0,32'h0, 0,0,32'h0,   1, 5'd2, 5'd3, 32'h50, 32'h7);
      tbl[8]  = mk(0, 32'h0, 32'h0,                 1, 5'd1, 32'h11,   0,0,5'd0,32'h0, 0,0,32'h0,   0, 5'd0, 5'd0, 32'h0, 32'h0);
      tbl[9]  = mk(1, enc_i(OP_BEQ,1,1,16'h4), 32'h100, 0,5'd0,32'h0, 0,0,5'd0,32'h0, 0,1,32'h110, 1, 5'd1, 5'd1, 32'h11, 32'h11);
      tbl[10] = mk(1, enc_r(1,0,6,FN_ADD), 32'h110, 0, 5'd0, 32'h0,    0,0,5'd0,32'h0, 0,0,32'h0,   1, 5'd1, 5'd6, 32'h11, 32'h0);
      tbl[11] = mk(1, enc_i(OP_BNE,6,0,16'hFFFE), 32'h200, 0,5'd0,32'h0, 0,0,5'd0,32'h0, 1,0,32'h0, 0, 5'd0, 5'd0, 32'h0, 32'h0);
      tbl[12] = mk(1, enc_i(OP_BNE,6,0,16'hFFFE), 32'h200, 0,5'd0,32'h0, 1,0,5'd6,32'h1, 0,1,32'h1F8, 1, 5'd6, 5'd0, 32'h0, 32'h0);
      tbl[13] = mk(1, enc_i(OP_BNE,6,0,16'hFFFE), 32'h204, 0,5'd0,32'h0, 1,1,5'd6,32'h1, 1,0,32'h0, 0, 5'd0, 5'd0, 32'h0, 32'h0);
      tbl[14] = mk(1, enc_r(1,0,0,FN_JR), 32'h300,  1, 5'd1, 32'h44,   0,0,5'd0,32'h0, 0,1,32'h44,  1, 5'd1, 5'd0, 32'h44, 32'h0);
      tbl[15] = mk(1, enc_r(1,0,0,FN_JR), 32'h304,  1, 5'd1, 32'h99,   1,0,5'd1,32'h88, 0,1,32'h88, 1, 5'd1, 5'd0, 32'h99, 32'h0);
      tbl[16] = mk(1, enc_i(OP_BEQ,1,2,16'h4), 32'h400, 0,5'd0,32'h0, 0,0,5'd0,32'h0, 0,0,32'h0,   1, 5'd1, 5'd2, 32'h99, 32'h50);
      tbl[17] = mk(1, enc_j(OP_JAL,26'h40), 32'h10, 0, 5'd0, 32'h0,    0,0,5'd0,32'h0, 0,1,32'h100, 1, 5'd0, 5'd31, 32'h14, 32'h0);
      tbl[18] = mk(1, enc_j(OP_J,26'h3), 32'hF0000004, 0,5'd0,32'h0,   0,0,5'd0,32'h0, 0,1,32'hF000000C, 1, 5'd0, 5'd0, 32'h0, 32'h0);
      tbl[19] = mk(0, enc_i(OP_BEQ,1,1,16'h4), 32'h500, 0,5'd0,32'h0, 0,0,5'd0,32'h0, 0,0,32'h0,   0, 5'd0, 5'd0, 32'h0, 32'h0);

      // reset with a pending EX/MEM load hazard on the presented branch
      reset_i = 1'b0; if_valid_i = 1'b1; instruction_i = enc_i(OP_BEQ,1,1,16'h4); pc_i = 32'h0;
      wb_write_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
      exmem_reg_write_i = 1'b1; exmem_mem_read_i = 1'b1; exmem_addr_i = 5'd1; exmem_data_i = '0;
      debug_addr_i = '0;
      #3;
      chk("reset_stall", 32'(stall_o), 32'h0);
      chk("reset_pc_load", 32'(pc_load_o), 32'h0);
      chk("reset_ex_valid", 32'(ex_valid_o), 32'h0);
      chk("reset_halted", 32'(halted_o), 32'h0);
      @(negedge clock_i);
      reset_i = 1'b1; if_valid_i = 1'b0;
      exmem_reg_write_i = 1'b0; exmem_mem_read_i = 1'b0;

      for (int i = 0; i < 20; i++) apply(i, tbl[i]);

      // debug read port, including same-cycle WB bypass and register 0
      @(negedge clock_i);
      if_valid_i = 1'b0; wb_write_i = 1'b0; exmem_reg_write_i = 1'b0; exmem_mem_read_i = 1'b0;
      debug_addr_i = 5'd5;
      #1 chk("debug_r5", debug_data_o, 32'h1234);
      wb_write_i = 1'b1; wb_addr_i = 5'd9; wb_data_i = 32'hABC; debug_addr_i = 5'd9;
      #1 chk("debug_bypass_r9", debug_data_o, 32'hABC);
      @(negedge clock_i);
      wb_addr_i = 5'd0; wb_data_i = 32'h777; debug_addr_i = 5'd0;
      #1 chk("debug_r0", debug_data_o, 32'h0);
      @(negedge clock_i);
      wb_write_i = 1'b0; debug_addr_i = 5'd9;
      #1 chk("debug_r9_stored", debug_data_o, 32'hABC);

      // HALT issues, then stall holds and bubbles follow
      @(negedge clock_i);
      if_valid_i = 1'b1; instruction_i = enc_j(OP_HALT, 26'h0); pc_i = 32'h600;
      #1 chk("halt_stall_before", 32'(stall_o), 32'h0);
      @(posedge clock_i); #1;
      chk("halt_halted", 32'(halted_o), 32'h1);
      chk("halt_ex_valid", 32'(ex_valid_o), 32'h1);
      chk("halt_ctrl_bit", 32'(ex_ctrl_o[CTRL_HALT]), 32'h1);
      chk("halt_ex_pc", ex_pc_o, 32'h600);
      chk("halt_ex_imm", ex_imm_o, 32'h0);
      chk("halt_ex_rt", 32'(ex_rt_o), 32'h0);
      chk("halt_stall_after", 32'(stall_o), 32'h1);
      @(negedge clock_i);
      instruction_i = enc_i(OP_BEQ,1,1,16'h4); pc_i = 32'h604;
      #1;
      chk("halted_stall", 32'(stall_o), 32'h1);
      chk("halted_no_redirect", 32'(pc_load_o), 32'h0);
      @(posedge clock_i); #1;
      chk("halted_bubble", 32'(ex_valid_o), 32'h0);
      chk("halted_sticky", 32'(halted_o), 32'h1);
      #2 reset_i = 1'b0;
      #1;
      chk("midreset_halted", 32'(halted_o), 32'h0);
      chk("midreset_stall", 32'(stall_o), 32'h0);
      chk("midreset_ex_valid", 32'(ex_valid_o), 32'h0);
      @(negedge clock_i);
      reset_i = 1'b1; instruction_i = enc_r(1,5,10,FN_ADD); pc_i = 32'h700;
      #1 chk("post_reset_stall", 32'(stall_o), 32'h0);
      @(posedge clock_i); #1;
      chk("post_reset_ex_valid", 32'(ex_valid_o), 32'h1);
      chk("post_reset_ex_rs", 32'(ex_rs_o), 32'h1);
      chk("post_reset_ex_rd", 32'(ex_rd_o), 32'hA);
      chk("post_reset_r1_cleared", ex_data_a_o, 32'h0);
      chk("post_reset_r5_cleared", ex_data_b_o, 32'h0);
      chk("post_reset_halted", 32'(halted_o), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
